midi_voice_ctrl: RTL and testbench



---
 rtl/midi_voice_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_midi_voice_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_ctrl.sv
// rtl/midi_voice_ctrl.sv - MIDI Note On/Off parser and round-robin voice allocator (option: MIDI_ALL_NOTES_OFF_EN)
module midi_voice_ctrl #(
    parameter int         VOICE_BITS = 2,
    parameter logic [3:0] CHANNEL    = 4'd0,
    localparam int        NUM_VOICES = 2 ** VOICE_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              i_byte,
    input  logic                    i_byte_vld,
    output logic [NUM_VOICES-1:0]   o_gate,
    output logic [7*NUM_VOICES-1:0] o_note,
    output logic [7*NUM_VOICES-1:0] o_vel,
    output logic                    o_upd,
    output logic [VOICE_BITS-1:0]   o_upd_voice
);

    typedef enum logic [1:0] {
        s_STATUS,
        s_DATA1,
        s_DATA2
    } state_t;

    // Input capture stage (edge k)
    logic [7:0] byte_q;
    logic       byte_vld_q;

    // Parser state; rs_q[7] == 0 means no running status
    state_t     state_q, state_d;
    logic [7:0] rs_q, rs_d;
    logic [6:0] d1_q, d1_d;

    // Decoded message (edge k+1)
    logic       msg_on_q, msg_on_d;
    logic       msg_off_q, msg_off_d;
    logic       msg_alloff_q, msg_alloff_d;
    logic [6:0] msg_note_q, msg_note_d;
    logic [6:0] msg_vel_q, msg_vel_d;

    // Voice state (edge k+2)
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [6:0]            note_q [NUM_VOICES];
    logic [6:0]            note_d [NUM_VOICES];
    logic [6:0]            vel_q  [NUM_VOICES];
    logic [6:0]            vel_d  [NUM_VOICES];
    logic [VOICE_BITS-1:0] steal_q, steal_d;
    logic                  upd_d;
    logic [VOICE_BITS-1:0] upd_voice_d;

    logic                  match_found, free_found;
    logic [VOICE_BITS-1:0] match_idx, free_idx, tgt;

    // Register the raw byte so parsing happens one edge after sampling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
        end else begin
            byte_q     <= i_byte;
            byte_vld_q <= i_byte_vld;
        end
    end

    // Parser state register and decoded-message register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= s_STATUS;
            rs_q         <= '0;
            d1_q         <= '0;
            msg_on_q     <= 1'b0;
            msg_off_q    <= 1'b0;
            msg_alloff_q <= 1'b0;
            msg_note_q   <= '0;
            msg_vel_q    <= '0;
        end else begin
            state_q      <= state_d;
            rs_q         <= rs_d;
            d1_q         <= d1_d;
            msg_on_q     <= msg_on_d;
            msg_off_q    <= msg_off_d;
            msg_alloff_q <= msg_alloff_d;
            msg_note_q   <= msg_note_d;
            msg_vel_q    <= msg_vel_d;
        end
    end

    // Parser next state: running status, message framing and dispatch decode
    always_comb begin
        state_d      = state_q;
        rs_d         = rs_q;
        d1_d         = d1_q;
        msg_on_d     = 1'b0;
        msg_off_d    = 1'b0;
        msg_alloff_d = 1'b0;
        msg_note_d   = d1_q;
        msg_vel_d    = byte_q[6:0];
        if (byte_vld_q) begin
            if (byte_q >= 8'hF8) begin
                // real-time bytes are transparent to the parser
                state_d = state_q;
            end else if (byte_q >= 8'hF0) begin
                rs_d    = '0;
                state_d = s_STATUS;
            end else if (byte_q[7]) begin
                rs_d    = byte_q;
                state_d = s_DATA1;
            end else begin
                case (state_q)
                    s_DATA1: begin
                        if (rs_q[7:4] != 4'hC && rs_q[7:4] != 4'hD) begin
                            d1_d    = byte_q[6:0];
                            state_d = s_DATA2;
                        end
                    end
                    s_DATA2: begin
                        state_d = s_DATA1;
                        if (rs_q[3:0] == CHANNEL) begin
                            case (rs_q[7:4])
                                4'h8: msg_off_d = 1'b1;
                                4'h9: begin
                                    if (byte_q[6:0] == 7'd0) msg_off_d = 1'b1;
                                    else                     msg_on_d  = 1'b1;
                                end
`ifdef MIDI_ALL_NOTES_OFF_EN
                                4'hB: begin
                                    if (d1_q == 7'h7B || d1_q == 7'h78) msg_alloff_d = 1'b1;
                                end
`endif
                                default: msg_on_d = 1'b0;
                            endcase
                        end
                    end
                    default: state_d = s_STATUS;
                endcase
            end
        end
    end

    // Voice lookup: lowest gated voice holding the note, lowest free voice
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (gate_q[v] && note_q[v] == msg_note_q) begin
                match_found = 1'b1;
                match_idx   = VOICE_BITS'(v);
            end
            if (!gate_q[v]) begin
                free_found = 1'b1;
                free_idx   = VOICE_BITS'(v);
            end
        end
    end

    // Allocator: apply at most one voice change per decoded message
    always_comb begin
        gate_d      = gate_q;
        note_d      = note_q;
        vel_d       = vel_q;
        steal_d     = steal_q;
        upd_d       = 1'b0;
        upd_voice_d = '0;
        tgt         = steal_q;
        if (msg_on_q) begin
            if (match_found) begin
                tgt = match_idx;
            end else if (free_found) begin
                tgt = free_idx;
            end else begin
                tgt     = steal_q;
                steal_d = steal_q + 1'b1;
            end
            gate_d[tgt] = 1'b1;
            note_d[tgt] = msg_note_q;
            vel_d[tgt]  = msg_vel_q;
            upd_d       = 1'b1;
            upd_voice_d = tgt;
        end else if (msg_off_q) begin
            if (match_found) begin
                gate_d[match_idx] = 1'b0;
                upd_d             = 1'b1;
                upd_voice_d       = match_idx;
            end
        end else if (msg_alloff_q) begin
            gate_d = '0;
            upd_d  = 1'b1;
        end
    end

    // Voice register bank and update strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_q      <= '0;
            steal_q     <= '0;
            o_upd       <= 1'b0;
            o_upd_voice <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= '0;
                vel_q[v]  <= '0;
            end
        end else begin
            gate_q      <= gate_d;
            steal_q     <= steal_d;
            o_upd       <= upd_d;
            o_upd_voice <= upd_voice_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= note_d[v];
                vel_q[v]  <= vel_d[v];
            end
        end
    end

    assign o_gate = gate_q;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign o_note[7*g +: 7] = note_q[g];
        assign o_vel[7*g +: 7]  = vel_q[g];
    end

endmodule

// File: tb/tb_midi_voice_ctrl.sv
// tb/tb_midi_voice_ctrl.sv - directed self-checking bench for midi_voice_ctrl
module tb_midi_voice_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_byte = 8'h00;
    logic        i_byte_vld = 1'b0;
    logic [3:0]  o_gate;
    logic [27:0] o_note;
    logic [27:0] o_vel;
    logic        o_upd;
    logic [1:0]  o_upd_voice;

    int          checks = 0;
    int          errors = 0;
    int          upd_cnt = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    int          prev_cyc = 0;
    int          base = 0;
    logic [1:0]  last_voice = 2'd0;

    always #5 clk = ~clk;

    midi_voice_ctrl #(
        .VOICE_BITS (2),
        .CHANNEL    (4'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_byte      (i_byte),
        .i_byte_vld  (i_byte_vld),
        .o_gate      (o_gate),
        .o_note      (o_note),
        .o_vel       (o_vel),
        .o_upd       (o_upd),
        .o_upd_voice (o_upd_voice)
    );

    // Pulse monitor sampled just after each rising edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (o_upd) begin
            upd_cnt    = upd_cnt + 1;
            prev_cyc   = last_cyc;
            last_cyc   = cyc;
            last_voice = o_upd_voice;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        i_byte     = b;
        i_byte_vld = 1'b1;
        @(negedge clk);
    endtask

    task automatic settle();
        i_byte_vld = 1'b0;
        i_byte     = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        i_byte_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_gate", 32'(o_gate), 32'h0);
        chk("rst_note", 32'(o_note), 32'h0);
        chk("rst_vel", 32'(o_vel), 32'h0);
        chk("rst_upd", 32'(o_upd), 32'h0);
        chk("rst_upd_voice", 32'(o_upd_voice), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Note On with exact latency
        base = upd_cnt;
        put(8'h90); put(8'h3C); put(8'h64);
        i_byte_vld = 1'b0;
        @(negedge clk);
        chk("on_upd_k1", 32'(o_upd), 32'h0);
        @(negedge clk);
        chk("on_upd_k2", 32'(o_upd), 32'h1);
        chk("on_upd_voice", 32'(o_upd_voice), 32'h0);
        chk("on_gate", 32'(o_gate), 32'h1);
        chk("on_note", 32'(o_note), 32'h3C);
        chk("on_vel", 32'(o_vel), 32'h64);
        @(negedge clk);
        chk("on_upd_k3", 32'(o_upd), 32'h0);
        chk("on_upd_cnt", 32'(upd_cnt - base), 32'd1);

        // Running status: second note to voice 1, then vel-0 note off
        base = upd_cnt;
        put(8'h40); put(8'h50); settle();
        chk("rs_gate", 32'(o_gate), 32'h3);
        chk("rs_note", 32'(o_note), 32'h203C);
        chk("rs_vel", 32'(o_vel), 32'h2864);
        chk("rs_voice", 32'(last_voice), 32'h1);
        chk("rs_cnt", 32'(upd_cnt - base), 32'd1);
        base = upd_cnt;
        put(8'h3C); put(8'h00); settle();
        chk("off_gate", 32'(o_gate), 32'h2);
        chk("off_note", 32'(o_note), 32'h203C);
        chk("off_vel", 32'(o_vel), 32'h2864);
        chk("off_voice", 32'(last_voice), 32'h0);
        chk("off_cnt", 32'(upd_cnt - base), 32'd1);

        // Fill all voices, then steal round-robin
        do_reset();
        put(8'h90); put(8'h30); put(8'h7F); put(8'h31); put(8'h7F);
        put(8'h32); put(8'h7F); put(8'h33); put(8'h7F); settle();
        chk("fill_gate", 32'(o_gate), 32'hF);
        chk("fill_note", 32'(o_note), 32'h66C98B0);
        base = upd_cnt;
        put(8'h34); put(8'h7F); settle();
        chk("steal0_note", 32'(o_note), 32'h66C98B4);
        chk("steal0_voice", 32'(last_voice), 32'h0);
        chk("steal0_cnt", 32'(upd_cnt - base), 32'd1);
        put(8'h35); put(8'h7F); settle();
        chk("steal1_note", 32'(o_note), 32'h66C9AB4);
        chk("steal1_voice", 32'(last_voice), 32'h1);
        put(8'h33); put(8'h10); settle();
        chk("retrig_vel", 32'(o_vel), 32'h21FFFFF);
        chk("retrig_voice", 32'(last_voice), 32'h3);
        chk("retrig_note", 32'(o_note), 32'h66C9AB4);
        put(8'h36); put(8'h7F); settle();
        chk("steal2_note", 32'(o_note), 32'h66D9AB4);
        chk("steal2_voice", 32'(last_voice), 32'h2);
        base = upd_cnt;
        put(8'h50); put(8'h00); settle();
        chk("off_nomatch_cnt", 32'(upd_cnt - base), 32'd0);
        chk("off_nomatch_gate", 32'(o_gate), 32'hF);

        // Filtering: real-time byte, other channel, program change
        do_reset();
        base = upd_cnt;
        put(8'h90); put(8'hF8); put(8'h3C); put(8'h64);
        i_byte_vld = 1'b0;
        @(negedge clk);
        chk("rt_upd_k1", 32'(o_upd), 32'h0);
        @(negedge clk);
        chk("rt_upd_k2", 32'(o_upd), 32'h1);
        chk("rt_gate", 32'(o_gate), 32'h1);
        chk("rt_note", 32'(o_note), 32'h3C);
        chk("rt_vel", 32'(o_vel), 32'h64);
        @(negedge clk);
        base = upd_cnt;
        put(8'h91); put(8'h3C); put(8'h64);
        put(8'hC0); put(8'h05); settle();
        chk("filt_cnt", 32'(upd_cnt - base), 32'd0);
        chk("filt_gate", 32'(o_gate), 32'h1);
        chk("filt_note", 32'(o_note), 32'h3C);
        chk("filt_vel", 32'(o_vel), 32'h64);

        // All Notes Off controller
        put(8'h90); put(8'h41); put(8'h20); put(8'h42); put(8'h20); settle();
        chk("ano_pre_gate", 32'(o_gate), 32'h7);
        base = upd_cnt;
        put(8'hB0); put(8'h7B); put(8'h00); settle();
`ifdef MIDI_ALL_NOTES_OFF_EN
        chk("ano_gate", 32'(o_gate), 32'h0);
        chk("ano_cnt", 32'(upd_cnt - base), 32'd1);
        chk("ano_voice", 32'(last_voice), 32'h0);
`else
        chk("ano_gate", 32'(o_gate), 32'h7);
        chk("ano_cnt", 32'(upd_cnt - base), 32'd0);
`endif
        chk("ano_note", 32'(o_note), 32'h10A0BC);

        // System message clears running status; following data dropped
        base = upd_cnt;
        put(8'hF0); put(8'h3C); put(8'h64); settle();
        chk("sys_cnt", 32'(upd_cnt - base), 32'd0);
        chk("sys_note", 32'(o_note), 32'h10A0BC);

        // Back-to-back bytes: two full Note On messages
        do_reset();
        base = upd_cnt;
        put(8'h90); put(8'h3C); put(8'h64); put(8'h90); put(8'h40); put(8'h50);
        settle();
        chk("b2b_cnt", 32'(upd_cnt - base), 32'd2);
        chk("b2b_spacing", 32'(last_cyc - prev_cyc), 32'd3);
        chk("b2b_gate", 32'(o_gate), 32'h3);
        chk("b2b_voice", 32'(last_voice), 32'h1);

        // Reset mid-message clears outputs at once; trailing data dropped
        put(8'h90); put(8'h3C);
        rst        = 1'b1;
        i_byte_vld = 1'b0;
        #1;
        chk("mrst_gate", 32'(o_gate), 32'h0);
        chk("mrst_note", 32'(o_note), 32'h0);
        chk("mrst_vel", 32'(o_vel), 32'h0);
        chk("mrst_upd", 32'(o_upd), 32'h0);
        @(negedge clk);
        rst  = 1'b0;
        base = upd_cnt;
        put(8'h64); put(8'h40); settle();
        chk("mrst_trail_cnt", 32'(upd_cnt - base), 32'd0);
        chk("mrst_trail_gate", 32'(o_gate), 32'h0);

        // Reset while a completed message is still in the pipeline
        put(8'h90); put(8'h3C); put(8'h64);
        rst        = 1'b1;
        i_byte_vld = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        base = upd_cnt;
        repeat (3) @(negedge clk);
        chk("prst_cnt", 32'(upd_cnt - base), 32'd0);
        chk("prst_gate", 32'(o_gate), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
